// File: rtl/operand_fetch_unit_pkg.sv
// rtl/operand_fetch_unit_pkg.sv - shared register indices, select encodings and fetch states
package operand_fetch_unit_pkg;

    // Architectural register indices shared with the write-register select logic
    localparam int SP_ADDR  = 29;
    localparam int RA_ADDR  = 31;
    localparam int ZERO_REG = 0;

    // Port-A source select encodings
    localparam logic [1:0] SEL_A_RS = 2'd0;
    localparam logic [1:0] SEL_A_RT = 2'd1;
    localparam logic [1:0] SEL_A_SP = 2'd2;
    localparam logic [1:0] SEL_A_RA = 2'd3;

    // Port-B source select encodings
    localparam logic [1:0] SEL_B_RT = 2'd0;
    localparam logic [1:0] SEL_B_RS = 2'd1;
    localparam logic [1:0] SEL_B_SP = 2'd2;
    localparam logic [1:0] SEL_B_RA = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_bypass_port.sv
// rtl/fetch_bypass_port.sv - per-port capture value with zero-register and write bypass
module fetch_bypass_port
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] bank_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] capture_data
);

    logic is_zero;
    logic hit;

    assign is_zero = (addr == ADDR_W'(ZERO_REG));
    // A write landing on the register being read this cycle wins over the stale bank value
    assign hit     = wr_en && (write_reg == addr);

    // Register zero reads as zero even if something tries to write it
    always_comb begin
        capture_data = bank_data;
        if (is_zero) begin
            capture_data = '0;
        end else if (hit) begin
            capture_data = write_data;
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - read-address select and one-shot A/B operand snapshot
module operand_fetch_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SP_ADDR = operand_fetch_unit_pkg::SP_ADDR,
    parameter int RA_ADDR = operand_fetch_unit_pkg::RA_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        sel_a,
    input  logic [1:0]        sel_b,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              busy,
    output logic              valid
);

    import operand_fetch_unit_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic              latch_addr;
    logic              capture;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a start is only honoured when no fetch is in flight
    always_comb begin
        state_next = state;
        latch_addr = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_addr = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    latch_addr = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode the read addresses from the current instruction fields
    always_comb begin
        addr_a = rs;
        addr_b = rt;
        case (sel_a)
            SEL_A_RS: addr_a = rs;
            SEL_A_RT: addr_a = rt;
            SEL_A_SP: addr_a = ADDR_W'(SP_ADDR);
            SEL_A_RA: addr_a = ADDR_W'(RA_ADDR);
            default:  addr_a = rs;
        endcase
        case (sel_b)
            SEL_B_RT: addr_b = rt;
            SEL_B_RS: addr_b = rs;
            SEL_B_SP: addr_b = ADDR_W'(SP_ADDR);
            SEL_B_RA: addr_b = ADDR_W'(RA_ADDR);
            default:  addr_b = rt;
        endcase
    end

    // Read addresses change only when a start is accepted, so they stay stable through FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_reg1 <= '0;
            read_reg2 <= '0;
        end else if (latch_addr) begin
            read_reg1 <= addr_a;
            read_reg2 <= addr_b;
        end
    end

    fetch_bypass_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .addr         (read_reg1),
        .bank_data    (read_data1),
        .wr_en        (wr_en),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .capture_data (cap_a)
    );

    fetch_bypass_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .addr         (read_reg2),
        .bank_data    (read_data2),
        .wr_en        (wr_en),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .capture_data (cap_b)
    );

    // Snapshot the operands at the closing edge of FETCH; later bank writes cannot touch them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out <= '0;
            b_out <= '0;
        end else if (capture) begin
            a_out <= cap_a;
            b_out <= cap_b;
        end
    end

    assign busy  = (state == FETCH);
    assign valid = (state == DONE);

endmodule
